// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: response states, port indices
// and the starvation counter width.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2
    } rsp_state_e;

    localparam int P0       = 0;
    localparam int P1       = 1;
    localparam int NPORTS   = 2;
    localparam int STARVE_W = 4;

endpackage

// File: rtl/dmem_arb_prio.sv
// Combinational grant decision: port 0 has fixed priority unless port 1 has been
// refused STARVE_LIMIT consecutive cycles, in which case port 1 is forced through.
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                en,
    input  logic                p0_req,
    input  logic                p1_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic [NPORTS-1:0]   grant
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    always_comb begin
        grant = '0;
        if (en) begin
            if (p1_req && (!p0_req || starve_cnt == LIMIT)) begin
                grant[P1] = 1'b1;
            end else if (p0_req) begin
                grant[P0] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the pipeline MEM stage (port 0) and a loader/debug
// port (port 1), with starvation relief for port 1 and a 1-cycle read response path.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [2:0]        p0_func3,
    output logic              p0_gnt,
    output logic              p0_stall,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [2:0]        p1_func3,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [1:0]        mem_byte_sel,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic [NPORTS-1:0]   grant;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    rsp_state_e          rd_owner_q, rd_owner_d;

    // Grants are suppressed while reset is held so nothing reaches the memory.
    dmem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .en        (~rst),
        .p0_req    (p0_req),
        .p1_req    (p1_req),
        .starve_cnt(starve_cnt_q),
        .grant     (grant)
    );

    assign p0_gnt   = grant[P0];
    assign p1_gnt   = grant[P1];
    assign p0_stall = p0_req & ~grant[P0] & ~rst;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!p1_req || grant[P1]) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_byte_sel = 2'b00;
        mem_r_en     = 1'b0;
        mem_w_en     = 1'b0;
        if (grant[P0]) begin
            mem_addr     = p0_addr;
            mem_wdata    = p0_wdata;
            mem_byte_sel = p0_func3[1:0];
            mem_r_en     = ~p0_we;
            mem_w_en     = p0_we;
        end else if (grant[P1]) begin
            mem_addr     = p1_addr;
            mem_wdata    = p1_wdata;
            mem_byte_sel = p1_func3[1:0];
            mem_r_en     = ~p1_we;
            mem_w_en     = p1_we;
        end
    end

    // The response state doubles as the read-data owner for the following cycle.
    always_comb begin
        rd_owner_d = IDLE;
        if (grant[P0] && !p0_we) begin
            rd_owner_d = RD0;
        end else if (grant[P1] && !p1_we) begin
            rd_owner_d = RD1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q   <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            rd_owner_q   <= rd_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        case (rd_owner_q)
            RD0: begin
                p0_rvalid = 1'b1;
                p0_rdata  = mem_rdata;
            end
            RD1: begin
                p1_rvalid = 1'b1;
                p1_rdata  = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a reference grant/starvation model plus a
// read-response scoreboard checked against a behavioural word memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int LIM = 4;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
    } req_t;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic [2:0]  p0_func3 = 0, p1_func3 = 0;
    logic        p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 0;
    logic        mem_r_en, mem_w_en;
    logic [1:0]  mem_byte_sel;

    logic [31:0] env_mem [64];
    logic [31:0] ref_mem [64];
    exp_t        exp_q [$];
    int          m_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_func3(p0_func3), .p0_gnt(p0_gnt), .p0_stall(p0_stall),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_func3(p1_func3), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .mem_byte_sel(mem_byte_sel), .mem_rdata(mem_rdata)
    );

    // Behavioural data memory: 1-cycle read latency, word addressed.
    always @(posedge clk) begin
        if (mem_r_en) mem_rdata <= env_mem[mem_addr[7:2]];
        if (mem_w_en) env_mem[mem_addr[7:2]] <= mem_wdata;
    end

    function automatic req_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] f);
        req_t t;
        t.req = r; t.we = w; t.addr = a; t.wdata = d; t.func3 = f;
        return t;
    endfunction

    // One clock of stimulus: drive, check at negedge against the model, advance model.
    task automatic cycle(input req_t a, input req_t b, output logic g1_seen);
        logic eg0, eg1, er0, er1;
        logic [31:0] ea, ed, erd0, erd1;
        logic [1:0] eb;
        exp_t e;
        p0_req = a.req; p0_we = a.we; p0_addr = a.addr; p0_wdata = a.wdata; p0_func3 = a.func3;
        p1_req = b.req; p1_we = b.we; p1_addr = b.addr; p1_wdata = b.wdata; p1_func3 = b.func3;
        @(negedge clk);
        eg1 = b.req && (!a.req || m_cnt == LIM);
        eg0 = a.req && !eg1;
        ea = 0; ed = 0; eb = 0;
        if (eg0) begin ea = a.addr; ed = a.wdata; eb = a.func3[1:0]; end
        else if (eg1) begin ea = b.addr; ed = b.wdata; eb = b.func3[1:0]; end
        g1_seen = p1_gnt;
        checks++; if (p0_gnt !== eg0) begin errors++; $display("FAIL p0_gnt got %0b exp %0b", p0_gnt, eg0); end
        checks++; if (p1_gnt !== eg1) begin errors++; $display("FAIL p1_gnt got %0b exp %0b", p1_gnt, eg1); end
        checks++; if (p0_stall !== (a.req && !eg0)) begin errors++; $display("FAIL p0_stall got %0b exp %0b", p0_stall, a.req && !eg0); end
        checks++; if (mem_r_en !== ((eg0 && !a.we) || (eg1 && !b.we))) begin errors++; $display("FAIL mem_r_en got %0b", mem_r_en); end
        checks++; if (mem_w_en !== ((eg0 && a.we) || (eg1 && b.we))) begin errors++; $display("FAIL mem_w_en got %0b", mem_w_en); end
        checks++; if (mem_addr !== ea) begin errors++; $display("FAIL mem_addr got %h exp %h", mem_addr, ea); end
        checks++; if (mem_wdata !== ed) begin errors++; $display("FAIL mem_wdata got %h exp %h", mem_wdata, ed); end
        checks++; if (mem_byte_sel !== eb) begin errors++; $display("FAIL mem_byte_sel got %0d exp %0d", mem_byte_sel, eb); end
        checks++; if (dut.starve_cnt_q !== 4'(m_cnt)) begin errors++; $display("FAIL starve_cnt got %0d exp %0d", dut.starve_cnt_q, m_cnt); end
        er0 = 0; er1 = 0; erd0 = 0; erd1 = 0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.port == 1'b0) begin er0 = 1; erd0 = e.data; end
            else begin er1 = 1; erd1 = e.data; end
        end
        checks++; if (p0_rvalid !== er0 || p0_rdata !== erd0) begin errors++; $display("FAIL p0_resp got %0b/%h exp %0b/%h", p0_rvalid, p0_rdata, er0, erd0); end
        checks++; if (p1_rvalid !== er1 || p1_rdata !== erd1) begin errors++; $display("FAIL p1_resp got %0b/%h exp %0b/%h", p1_rvalid, p1_rdata, er1, erd1); end
        if (eg0 && !a.we) exp_q.push_back({1'b0, ref_mem[a.addr[7:2]]});
        if (eg1 && !b.we) exp_q.push_back({1'b1, ref_mem[b.addr[7:2]]});
        if (eg0 && a.we) ref_mem[a.addr[7:2]] = a.wdata;
        if (eg1 && b.we) ref_mem[b.addr[7:2]] = b.wdata;
        if (!b.req || eg1) m_cnt = 0;
        else if (m_cnt != LIM) m_cnt = m_cnt + 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        p0_req = 1; p1_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (p0_gnt !== 0 || p1_gnt !== 0 || p0_stall !== 0) begin errors++; $display("FAIL reset_gnt got %0b%0b stall %0b exp 000", p0_gnt, p1_gnt, p0_stall); end
        checks++; if (mem_r_en !== 0 || mem_w_en !== 0 || mem_addr !== 0) begin errors++; $display("FAIL reset_mem got r%0b w%0b a%h exp 0", mem_r_en, mem_w_en, mem_addr); end
        checks++; if (p0_rvalid !== 0 || p1_rvalid !== 0 || p0_rdata !== 0 || p1_rdata !== 0) begin errors++; $display("FAIL reset_rsp got rv %0b%0b exp 00", p0_rvalid, p1_rvalid); end
        p0_req = 0; p1_req = 0;
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_p0_read;
        logic g;
        cycle(mk(1, 0, 32'h10, 0, 3'b010), mk(0, 0, 0, 0, 0), g);
        cycle(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), g);
    endtask

    task automatic test_starvation;
        logic g;
        int first = 0;
        for (int i = 1; i <= 8 && first == 0; i++) begin
            cycle(mk(1, 0, 32'(i * 4), 0, 3'b010), mk(1, 1, 32'h20, 32'h55, 3'b000), g);
            if (g) first = i;
        end
        checks++; if (first != LIM + 1) begin errors++; $display("FAIL starve_grant_cycle got %0d exp %0d", first, LIM + 1); end
        cycle(mk(1, 0, 32'h24, 0, 3'b010), mk(0, 0, 0, 0, 0), g);
        cycle(mk(1, 0, 32'h20, 0, 3'b010), mk(0, 0, 0, 0, 0), g);
        cycle(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), g);
    endtask

    task automatic test_alternate;
        logic g;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) cycle(mk(1, 0, 32'(8 * i), 0, 3'b001), mk(0, 0, 0, 0, 0), g);
            else            cycle(mk(0, 0, 0, 0, 0), mk(1, 0, 32'(8 * i + 4), 0, 3'b000), g);
            checks++; if (p0_rvalid === 1'b1 && p1_rvalid === 1'b1) begin errors++; $display("FAIL both_rvalid got 11 exp not both"); end
        end
        cycle(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), g);
    endtask

    task automatic test_idle;
        logic g;
        repeat (3) cycle(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), g);
    endtask

    task automatic test_drop;
        logic g;
        int first = 0;
        for (int i = 0; i < 3; i++) cycle(mk(1, 0, 32'h40, 0, 3'b010), mk(1, 0, 32'h44, 0, 3'b010), g);
        cycle(mk(1, 0, 32'h40, 0, 3'b010), mk(0, 0, 0, 0, 0), g);
        for (int i = 1; i <= 8 && first == 0; i++) begin
            cycle(mk(1, 0, 32'h48, 0, 3'b010), mk(1, 0, 32'h44, 0, 3'b010), g);
            if (g) first = i;
        end
        checks++; if (first != LIM + 1) begin errors++; $display("FAIL drop_restart got %0d exp %0d", first, LIM + 1); end
        cycle(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), g);
    endtask

    task automatic test_random;
        logic g;
        req_t a, b;
        for (int i = 0; i < 200; i++) begin
            a = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 3'($urandom_range(0, 7)));
            b = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom, 3'($urandom_range(0, 7)));
            cycle(a, b, g);
        end
        cycle(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), g);
        cycle(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), g);
    endtask

    task automatic test_reset_mid_read;
        logic g;
        p0_req = 0; p1_req = 1; p1_we = 0; p1_addr = 32'h30; p1_func3 = 3'b010;
        @(negedge clk);
        checks++; if (p1_gnt !== 1'b1 || mem_r_en !== 1'b1) begin errors++; $display("FAIL rst_pre_gnt got %0b/%0b exp 1/1", p1_gnt, mem_r_en); end
        rst = 1;
        p0_req = 1; p0_we = 0; p0_addr = 32'h10;
        #1;
        checks++; if (p1_gnt !== 0 || p0_gnt !== 0 || mem_r_en !== 0 || p0_stall !== 0) begin errors++; $display("FAIL rst_async got g%0b%0b r%0b s%0b exp 0", p0_gnt, p1_gnt, mem_r_en, p0_stall); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (p1_rvalid !== 0 || p0_rvalid !== 0 || p1_rdata !== 0 || p0_rdata !== 0) begin errors++; $display("FAIL rst_rvalid got %0b%0b exp 00", p0_rvalid, p1_rvalid); end
        checks++; if (dut.rd_owner_q !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dut.rd_owner_q, IDLE); end
        checks++; if (mem_addr !== 0 || mem_w_en !== 0 || p0_gnt !== 0) begin errors++; $display("FAIL rst_outs got a%h w%0b g%0b exp 0", mem_addr, mem_w_en, p0_gnt); end
        p0_req = 0; p1_req = 0;
        rst = 0;
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk); #1;
        cycle(mk(1, 0, 32'h10, 0, 3'b010), mk(0, 0, 0, 0, 0), g);
        cycle(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0), g);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5000000;
            ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'hA5000000;
        end
        env_mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        test_reset();
        test_p0_read();
        test_idle();
        test_starvation();
        test_alternate();
        test_drop();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
